// File: rtl/output_port_credit_arbiter.sv
// output_port_credit_arbiter: per-channel FIFOs with credit flow control, merged by a round-robin arbiter
// onto one registered packet stream.
module output_port_credit_arbiter #(
    parameter int NUM_OUT_PORTS   = 8,
    parameter int PORT_SEL_BITS   = 3,
    parameter int NUM_LEAF_BITS   = 6,
    parameter int NUM_PORT_BITS   = 4,
    parameter int NUM_ADDR_BITS   = 7,
    parameter int PAYLOAD_BITS    = 64,
    parameter int FIFO_DEPTH_BITS = 2
) (
    input  logic                                                              clk_bft,
    input  logic                                                              reset,
    input  logic                                                              cfg_wr_en,
    input  logic [PORT_SEL_BITS-1:0]                                          cfg_port,
    input  logic                                                              cfg_enable,
    input  logic [NUM_LEAF_BITS-1:0]                                          cfg_dst_leaf,
    input  logic [NUM_PORT_BITS-1:0]                                          cfg_dst_port,
    input  logic [NUM_ADDR_BITS:0]                                            cfg_credit,
    input  logic [PAYLOAD_BITS*NUM_OUT_PORTS-1:0]                             din_leaf_user2interface,
    input  logic [NUM_OUT_PORTS-1:0]                                          vld_user2b_out,
    output logic [NUM_OUT_PORTS-1:0]                                          ack_b_out2user,
    input  logic                                                              credit_ret_vld,
    input  logic [PORT_SEL_BITS-1:0]                                          credit_ret_port,
    input  logic [NUM_ADDR_BITS:0]                                            credit_ret_cnt,
    output logic [NUM_LEAF_BITS+NUM_PORT_BITS+NUM_ADDR_BITS+PAYLOAD_BITS-1:0] pkt_out,
    output logic                                                              pkt_vld,
    input  logic                                                              pkt_rdy,
    output logic [NUM_OUT_PORTS-1:0]                                          empty,
    output logic [NUM_OUT_PORTS-1:0]                                          credit_zero
);
    localparam int N        = NUM_OUT_PORTS;
    localparam int FB       = FIFO_DEPTH_BITS;
    localparam int AB       = NUM_ADDR_BITS;
    localparam int PKT_BITS = NUM_LEAF_BITS + NUM_PORT_BITS + NUM_ADDR_BITS + PAYLOAD_BITS;
    localparam logic [AB+1:0] CMAX = {2'b01, {AB{1'b0}}};

    logic [PAYLOAD_BITS-1:0]  mem_q [N][2**FB];
    logic [FB-1:0]            wp_q [N];
    logic [FB-1:0]            rp_q [N];
    logic [FB:0]              cnt_q [N];
    logic [FB:0]              cnt_d [N];
    logic [N-1:0]             en_q;
    logic [NUM_LEAF_BITS-1:0] leaf_q [N];
    logic [NUM_PORT_BITS-1:0] port_q [N];
    logic [AB-1:0]            addr_q [N];
    logic [AB-1:0]            addr_d [N];
    logic [AB:0]              cred_q [N];
    logic [AB:0]              cred_d [N];
    logic [AB+1:0]            sum;
    logic [PORT_SEL_BITS-1:0] rr_q, rr_d, g, idx;
    logic [PKT_BITS-1:0]      pkt_q, pkt_d;
    logic                     vld_q, vld_d, load, found;
    logic [N-1:0]             full, wr, elig, pop, cfg_hit, ret_hit;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            full[i]        = cnt_q[i][FB];
            empty[i]       = cnt_q[i] == '0;
            credit_zero[i] = cred_q[i] == '0;
            wr[i]          = vld_user2b_out[i] && !full[i];
            elig[i]        = en_q[i] && !empty[i] && !credit_zero[i];
            cfg_hit[i]     = cfg_wr_en && cfg_port == PORT_SEL_BITS'(i);
            ret_hit[i]     = credit_ret_vld && credit_ret_port == PORT_SEL_BITS'(i);
        end
    end

    // Round-robin search starts just after the last granted channel.
    always_comb begin
        found = 1'b0;
        g     = rr_q;
        idx   = rr_q;
        for (int k = 1; k <= N; k++) begin
            idx = PORT_SEL_BITS'((int'(rr_q) + k) % N);
            if (!found && elig[idx]) begin
                found = 1'b1;
                g     = idx;
            end
        end
        load  = !vld_q || pkt_rdy;
        pop   = (load && found) ? N'(1) << g : '0;
        pkt_d = (load && found) ? {leaf_q[g], port_q[g], addr_q[g], mem_q[g][rp_q[g]]} : pkt_q;
        vld_d = load ? found : vld_q;
        rr_d  = (load && found) ? g : rr_q;
    end

    // A config write wins over a same-cycle grant decrement or credit return.
    always_comb begin
        sum = '0;
        for (int i = 0; i < N; i++) begin
            sum       = {1'b0, cred_q[i]} - {{(AB + 1){1'b0}}, pop[i]} + (ret_hit[i] ? {1'b0, credit_ret_cnt} : '0);
            cred_d[i] = cfg_hit[i] ? cfg_credit : (sum > CMAX ? CMAX[AB:0] : sum[AB:0]);
            addr_d[i] = cfg_hit[i] ? '0 : addr_q[i] + AB'(pop[i]);
            cnt_d[i]  = cnt_q[i] + (FB + 1)'(wr[i]) - (FB + 1)'(pop[i]);
        end
    end

    always_ff @(posedge clk_bft or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                wp_q[i]   <= '0;
                rp_q[i]   <= '0;
                cnt_q[i]  <= '0;
                leaf_q[i] <= '0;
                port_q[i] <= '0;
                addr_q[i] <= '0;
                cred_q[i] <= '0;
            end
            en_q  <= '0;
            rr_q  <= '0;
            pkt_q <= '0;
            vld_q <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (wr[i])  wp_q[i] <= wp_q[i] + FB'(1);
                if (pop[i]) rp_q[i] <= rp_q[i] + FB'(1);
                cnt_q[i]  <= cnt_d[i];
                addr_q[i] <= addr_d[i];
                cred_q[i] <= cred_d[i];
                if (cfg_hit[i]) begin
                    en_q[i]   <= cfg_enable;
                    leaf_q[i] <= cfg_dst_leaf;
                    port_q[i] <= cfg_dst_port;
                end
            end
            rr_q  <= rr_d;
            pkt_q <= pkt_d;
            vld_q <= vld_d;
        end
    end

    always_ff @(posedge clk_bft) begin
        for (int i = 0; i < N; i++)
            if (wr[i]) mem_q[i][wp_q[i]] <= din_leaf_user2interface[PAYLOAD_BITS*i +: PAYLOAD_BITS];
    end

    assign ack_b_out2user = ~full;
    assign pkt_out        = pkt_q;
    assign pkt_vld        = vld_q;
endmodule

// File: tb/tb_output_port_credit_arbiter.sv
// tb_output_port_credit_arbiter: directed stimulus with hand-computed expectations for the credit arbiter.
module tb_output_port_credit_arbiter;
    localparam int N    = 8;
    localparam int PB   = 64;
    localparam int PKTW = 81;

    logic            clk_bft = 1'b0;
    logic            reset = 1'b0;
    logic            cfg_wr_en = 1'b0;
    logic [2:0]      cfg_port = '0;
    logic            cfg_enable = 1'b0;
    logic [5:0]      cfg_dst_leaf = '0;
    logic [3:0]      cfg_dst_port = '0;
    logic [7:0]      cfg_credit = '0;
    logic [PB*N-1:0] din = '0;
    logic [N-1:0]    vld = '0;
    logic [N-1:0]    ack;
    logic            credit_ret_vld = 1'b0;
    logic [2:0]      credit_ret_port = '0;
    logic [7:0]      credit_ret_cnt = '0;
    logic [PKTW-1:0] pkt_out;
    logic            pkt_vld;
    logic            pkt_rdy = 1'b1;
    logic [N-1:0]    empty;
    logic [N-1:0]    credit_zero;
    int              vecs = 0;
    int              errs = 0;
    int              lf [N];
    int              pt [N];
    int              ord [3];
    int              c;

    output_port_credit_arbiter dut (
        .clk_bft(clk_bft), .reset(reset), .cfg_wr_en(cfg_wr_en), .cfg_port(cfg_port),
        .cfg_enable(cfg_enable), .cfg_dst_leaf(cfg_dst_leaf), .cfg_dst_port(cfg_dst_port),
        .cfg_credit(cfg_credit), .din_leaf_user2interface(din), .vld_user2b_out(vld),
        .ack_b_out2user(ack), .credit_ret_vld(credit_ret_vld), .credit_ret_port(credit_ret_port),
        .credit_ret_cnt(credit_ret_cnt), .pkt_out(pkt_out), .pkt_vld(pkt_vld), .pkt_rdy(pkt_rdy),
        .empty(empty), .credit_zero(credit_zero)
    );

    always #5 clk_bft = ~clk_bft;

    task automatic tick;
        @(posedge clk_bft);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] want);
        vecs++;
        assert (obs === want) else begin
            errs++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, want);
        end
    endtask

    task automatic set_cfg(input int ch, input logic en, input int leaf, input int port, input int cr);
        cfg_wr_en    = 1'b1;
        cfg_port     = 3'(ch);
        cfg_enable   = en;
        cfg_dst_leaf = 6'(leaf);
        cfg_dst_port = 4'(port);
        cfg_credit   = 8'(cr);
    endtask

    task automatic put(input int ch, input logic [63:0] d);
        din[PB*ch +: PB] = d;
    endtask

    function automatic logic [127:0] pk(input int leaf, input int port, input int addr, input logic [63:0] d);
        return 128'({6'(leaf), 4'(port), 7'(addr), d});
    endfunction

    initial begin
        lf[0] = 5;  pt[0] = 2;
        lf[3] = 9;  pt[3] = 3;
        lf[7] = 33; pt[7] = 7;
        ord[0] = 3; ord[1] = 7; ord[2] = 0;

        // 1. reset state, then credit-limited sending on ch0
        tick;
        tick;
        reset = 1'b1;
        chk("rst_vld", 128'(pkt_vld), 128'(0));
        chk("rst_pkt", 128'(pkt_out), 128'(0));
        chk("rst_ack", 128'(ack), 128'(8'hff));
        chk("rst_empty", 128'(empty), 128'(8'hff));
        chk("rst_czero", 128'(credit_zero), 128'(8'hff));
        set_cfg(0, 1'b1, 5, 2, 4);
        tick;
        cfg_wr_en = 1'b0;
        vld = 8'b0000_0001;
        for (int k = 0; k < 6; k++) begin
            put(0, 64'hA5A5_0000_0000_0000 + 64'(k));
            tick;
            chk("t1_vld", 128'(pkt_vld), 128'(k >= 1 && k <= 4));
            if (k >= 1 && k <= 4)
                chk("t1_pkt", 128'(pkt_out), pk(5, 2, k - 1, 64'hA5A5_0000_0000_0000 + 64'(k - 1)));
        end
        vld = '0;
        chk("t1_czero", 128'(credit_zero[0]), 128'(1));
        chk("t1_pending", 128'(empty[0]), 128'(0));
        tick;
        chk("t1_nocredit_vld", 128'(pkt_vld), 128'(0));
        credit_ret_vld = 1'b1; credit_ret_port = 3'd0; credit_ret_cnt = 8'd2;
        tick;
        credit_ret_vld = 1'b0;
        chk("t1_ret_czero", 128'(credit_zero[0]), 128'(0));
        chk("t1_ret_vld", 128'(pkt_vld), 128'(0));
        tick;
        chk("t1_pkt4", 128'(pkt_out), pk(5, 2, 4, 64'hA5A5_0000_0000_0004));
        tick;
        chk("t1_pkt5", 128'(pkt_out), pk(5, 2, 5, 64'hA5A5_0000_0000_0005));
        tick;
        chk("t1_end_vld", 128'(pkt_vld), 128'(0));
        chk("t1_end_empty", 128'(empty[0]), 128'(1));
        chk("t1_end_czero", 128'(credit_zero[0]), 128'(1));

        // 2. round robin across ch0, ch3, ch7 with full credit
        set_cfg(0, 1'b1, 5, 2, 128);
        tick;
        set_cfg(3, 1'b1, 9, 3, 128);
        tick;
        set_cfg(7, 1'b1, 33, 7, 128);
        tick;
        cfg_wr_en = 1'b0;
        for (int t = 0; t < 14; t++) begin
            if (t < 4) begin
                put(0, 64'hC0DE_0000_0000_0000 + 64'(t));
                put(3, 64'hC0DE_0000_0000_0000 + 64'(3 * 256 + t));
                put(7, 64'hC0DE_0000_0000_0000 + 64'(7 * 256 + t));
                vld = 8'b1000_1001;
            end else begin
                vld = '0;
            end
            tick;
            chk("t2_vld", 128'(pkt_vld), 128'(t >= 1 && t <= 12));
            if (t >= 1 && t <= 12) begin
                c = ord[(t - 1) % 3];
                chk("t2_pkt", 128'(pkt_out),
                    pk(lf[c], pt[c], (t - 1) / 3, 64'hC0DE_0000_0000_0000 + 64'(c * 256 + (t - 1) / 3)));
            end
        end

        // 3. downstream stall holds the output register and the FIFOs
        pkt_rdy = 1'b0;
        vld = 8'b1000_1000;
        for (int t = 0; t < 2; t++) begin
            put(3, 64'h5700_0000_0000_0000 + 64'(3 * 256 + t));
            put(7, 64'h5700_0000_0000_0000 + 64'(7 * 256 + t));
            tick;
            chk("t3_fill_vld", 128'(pkt_vld), 128'(t));
        end
        vld = '0;
        for (int t = 0; t < 5; t++) begin
            tick;
            chk("t3_hold_pkt", 128'(pkt_out), pk(9, 3, 4, 64'h5700_0000_0000_0300));
            chk("t3_hold_vld", 128'(pkt_vld), 128'(1));
        end
        chk("t3_ch3_kept", 128'(empty[3]), 128'(0));
        pkt_rdy = 1'b1;
        tick;
        chk("t3_rel0", 128'(pkt_out), pk(33, 7, 4, 64'h5700_0000_0000_0700));
        tick;
        chk("t3_rel1", 128'(pkt_out), pk(9, 3, 5, 64'h5700_0000_0000_0301));
        tick;
        chk("t3_rel2", 128'(pkt_out), pk(33, 7, 5, 64'h5700_0000_0000_0701));
        tick;
        chk("t3_rel_vld", 128'(pkt_vld), 128'(0));

        // 4. FIFO full back-pressure on ch1
        vld = 8'b0000_0010;
        for (int k = 0; k < 4; k++) begin
            put(1, 64'h4444_0000_0000_0000 + 64'(k));
            tick;
            chk("t4_ack_fill", 128'(ack[1]), 128'(k < 3));
        end
        put(1, 64'h4444_0000_0000_0004);
        tick;
        chk("t4_ack_full", 128'(ack[1]), 128'(0));
        vld = '0;
        set_cfg(1, 1'b1, 1, 1, 128);
        tick;
        cfg_wr_en = 1'b0;
        chk("t4_cfg_vld", 128'(pkt_vld), 128'(0));
        for (int k = 0; k < 4; k++) begin
            tick;
            chk("t4_ack_back", 128'(ack[1]), 128'(1));
            chk("t4_pkt", 128'(pkt_out), pk(1, 1, k, 64'h4444_0000_0000_0000 + 64'(k)));
        end
        tick;
        chk("t4_end_vld", 128'(pkt_vld), 128'(0));
        chk("t4_end_empty", 128'(empty[1]), 128'(1));

        // 5. grant, credit return and config on ch2 in the same cycle
        set_cfg(2, 1'b1, 2, 4, 3);
        tick;
        cfg_wr_en = 1'b0;
        vld = 8'b0000_0100;
        put(2, 64'h5555_0000_0000_0000);
        tick;
        chk("t5_first_vld", 128'(pkt_vld), 128'(0));
        put(2, 64'h5555_0000_0000_0001);
        tick;
        vld = '0;
        chk("t5_pkt0", 128'(pkt_out), pk(2, 4, 0, 64'h5555_0000_0000_0000));
        set_cfg(2, 1'b1, 3, 4, 10);
        credit_ret_vld = 1'b1; credit_ret_port = 3'd2; credit_ret_cnt = 8'd5;
        tick;
        cfg_wr_en = 1'b0;
        credit_ret_vld = 1'b0;
        chk("t5_old_fields", 128'(pkt_out), pk(2, 4, 1, 64'h5555_0000_0000_0001));
        chk("t5_czero", 128'(credit_zero[2]), 128'(0));
        vld = 8'b0000_0100;
        for (int k = 0; k < 12; k++) begin
            if (k < 11) put(2, 64'h5555_0000_0000_0010 + 64'(k));
            else vld = '0;
            tick;
            chk("t5_vld", 128'(pkt_vld), 128'(k >= 1 && k <= 10));
            if (k >= 1 && k <= 10)
                chk("t5_pkt", 128'(pkt_out), pk(3, 4, k - 1, 64'h5555_0000_0000_0010 + 64'(k - 1)));
        end
        chk("t5_end_czero", 128'(credit_zero[2]), 128'(1));
        chk("t5_end_pending", 128'(empty[2]), 128'(0));

        // 6. asynchronous reset while a packet is held
        pkt_rdy = 1'b0;
        vld = 8'b0000_0001;
        put(0, 64'h6666_0000_0000_0000);
        tick;
        put(0, 64'h6666_0000_0000_0001);
        tick;
        vld = '0;
        chk("t6_pre_vld", 128'(pkt_vld), 128'(1));
        chk("t6_pre_pkt", 128'(pkt_out), pk(5, 2, 4, 64'h6666_0000_0000_0000));
        #2;
        reset = 1'b0;
        #1;
        chk("t6_rst_vld", 128'(pkt_vld), 128'(0));
        chk("t6_rst_pkt", 128'(pkt_out), 128'(0));
        chk("t6_rst_empty", 128'(empty), 128'(8'hff));
        chk("t6_rst_czero", 128'(credit_zero), 128'(8'hff));
        chk("t6_rst_ack", 128'(ack), 128'(8'hff));
        tick;
        reset = 1'b1;
        pkt_rdy = 1'b1;
        tick;
        chk("t6_post_vld", 128'(pkt_vld), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
